// File: rtl/disp_pkg.sv
// Shared constants for the display cursor: quadrature decoder state encoding
// and the AB code points of one detent.
package disp_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_A1   = 3'd1;
    localparam logic [2:0] ST_AB_A = 3'd2;
    localparam logic [2:0] ST_B_A  = 3'd3;
    localparam logic [2:0] ST_B1   = 3'd4;
    localparam logic [2:0] ST_AB_B = 3'd5;
    localparam logic [2:0] ST_A_B  = 3'd6;
    localparam logic [2:0] ST_WAIT = 3'd7;

    // {A,B} codes; rest position is 00
    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    // Code that the encoder shows while the decoder sits in a given state.
    function automatic logic [1:0] st_code(input logic [2:0] st);
        case (st)
            ST_A1, ST_A_B:   st_code = AB_10;
            ST_AB_A, ST_AB_B: st_code = AB_11;
            ST_B_A, ST_B1:   st_code = AB_01;
            default:         st_code = AB_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Full-detent quadrature decoder: registers the encoder pair, tracks the detent
// and emits step/error pulses plus same-cycle event strobes for the cursor logic.
//   state   | meaning
//   IDLE    | at rest, AB=00
//   A1      | AB=10, A-leading detent started
//   AB_A    | AB=11 reached via A
//   B_A     | AB=01 via A, next 00 completes a down step
//   B1      | AB=01, B-leading detent started
//   AB_B    | AB=11 reached via B
//   A_B     | AB=10 via B, next 00 completes an up step
//   WAIT    | after an illegal jump or reset off-rest, waiting for 00
module quad_decoder
    import disp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rot_a,
    input  logic rot_b,
    output logic step_up,
    output logic step_dn,
    output logic seq_err,
    output logic up_evt,
    output logic dn_evt
);

    logic [2:0] state_q, state_d;
    logic [1:0] ab_q, ab_d;
    logic       loaded_q, loaded_d;
    logic       first_q, first_d;
    logic       step_up_q, step_up_d;
    logic       step_dn_q, step_dn_d;
    logic       seq_err_q, seq_err_d;
    logic       live;

    // The first sample after reset is only classified (rest or not), never stepped on.
    assign live = loaded_q & ~first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ab_q      <= AB_00;
            loaded_q  <= 1'b0;
            first_q   <= 1'b1;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ab_q      <= ab_d;
            loaded_q  <= loaded_d;
            first_q   <= first_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ab_d     = {rot_a, rot_b};
        loaded_d = 1'b1;
        first_d  = first_q & ~loaded_q;
        if (!loaded_q) begin
            state_d = ST_IDLE;
        end else if (first_q) begin
            state_d = (ab_q == AB_00) ? ST_IDLE : ST_WAIT;
        end else begin
            case (state_q)
                ST_IDLE: case (ab_q)
                    AB_10:   state_d = ST_A1;
                    AB_01:   state_d = ST_B1;
                    AB_11:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_A1: case (ab_q)
                    AB_11:   state_d = ST_AB_A;
                    AB_00:   state_d = ST_IDLE;
                    AB_01:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_AB_A: case (ab_q)
                    AB_01:   state_d = ST_B_A;
                    AB_10:   state_d = ST_A1;
                    AB_00:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_B_A: case (ab_q)
                    AB_00:   state_d = ST_IDLE;
                    AB_11:   state_d = ST_AB_A;
                    AB_10:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_B1: case (ab_q)
                    AB_11:   state_d = ST_AB_B;
                    AB_00:   state_d = ST_IDLE;
                    AB_10:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_AB_B: case (ab_q)
                    AB_10:   state_d = ST_A_B;
                    AB_01:   state_d = ST_B1;
                    AB_00:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                ST_A_B: case (ab_q)
                    AB_00:   state_d = ST_IDLE;
                    AB_11:   state_d = ST_AB_B;
                    AB_01:   state_d = ST_WAIT;
                    default: state_d = state_q;
                endcase
                default: state_d = (ab_q == AB_00) ? ST_IDLE : ST_WAIT;
            endcase
        end
    end

    always_comb begin
        step_up_d = live && (state_q == ST_A_B) && (ab_q == AB_00);
        step_dn_d = live && (state_q == ST_B_A) && (ab_q == AB_00);
        seq_err_d = live && (state_q != ST_WAIT) && ((ab_q ^ st_code(state_q)) == AB_11);
    end

    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign seq_err = seq_err_q;
    assign up_evt  = step_up_d;
    assign dn_evt  = step_dn_d;

endmodule

// File: rtl/disp_cursor.sv
// Multi-channel display cursor: one bounded address per channel, stepped by the
// quadrature decoder and cleared by the centre push on the selected channel.
module disp_cursor
    import disp_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int ADDR_W   = 5,
    parameter int ADDR_MAX = (1 << ADDR_W) - 1,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rot_a,
    input  logic              rot_b,
    input  logic              rot_push,
    input  logic [CH_W-1:0]   chan_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              step_up,
    output logic              step_dn,
    output logic              changed,
    output logic              seq_err
);

    localparam logic [ADDR_W:0] MAX_X = (ADDR_W + 1)'(ADDR_MAX);

    logic [ADDR_W-1:0] cur_q [CHANNELS];
    logic [ADDR_W-1:0] cur_d [CHANNELS];
    logic              push_q, push_d;
    logic              push_prev_q, push_prev_d;
    logic              changed_q, changed_d;
    logic              up_evt, dn_evt, push_rise;

    quad_decoder u_quad (
        .clk     (clk),
        .rst     (rst),
        .rot_a   (rot_a),
        .rot_b   (rot_b),
        .step_up (step_up),
        .step_dn (step_dn),
        .seq_err (seq_err),
        .up_evt  (up_evt),
        .dn_evt  (dn_evt)
    );

    // Bounds are checked one bit wider so ADDR_MAX below the natural top still wraps correctly.
    function automatic logic [ADDR_W-1:0] bump_up(input logic [ADDR_W-1:0] c);
        logic [ADDR_W:0] x;
        x = {1'b0, c};
        if (x >= MAX_X) begin
            bump_up = (SATURATE != 0) ? c : '0;
        end else begin
            x       = x + (ADDR_W + 1)'(1);
            bump_up = x[ADDR_W-1:0];
        end
    endfunction

    function automatic logic [ADDR_W-1:0] bump_dn(input logic [ADDR_W-1:0] c);
        logic [ADDR_W:0] x;
        x = {1'b0, c};
        if (x == '0) begin
            bump_dn = (SATURATE != 0) ? c : MAX_X[ADDR_W-1:0];
        end else begin
            x       = x - (ADDR_W + 1)'(1);
            bump_dn = x[ADDR_W-1:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) cur_q[i] <= '0;
            push_q      <= 1'b0;
            push_prev_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            push_q      <= push_d;
            push_prev_q <= push_prev_d;
            changed_q   <= changed_d;
        end
    end

    assign push_rise = push_q & ~push_prev_q;

    always_comb begin
        cur_d       = cur_q;
        changed_d   = 1'b0;
        push_d      = rot_push;
        push_prev_d = push_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((chan_sel == CH_W'(i)) && (push_rise || up_evt || dn_evt)) begin
                changed_d = 1'b1;
                if (push_rise)   cur_d[i] = '0;
                else if (up_evt) cur_d[i] = bump_up(cur_q[i]);
                else             cur_d[i] = bump_dn(cur_q[i]);
            end
        end
    end

    always_comb begin
        addr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_sel == CH_W'(i)) addr = cur_q[i];
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_disp_cursor.sv
// Bench for disp_cursor: a wrapping 4x5-bit instance and a saturating 3x4-bit
// instance (ADDR_MAX=12) share stimulus and are checked against a detent model.
module tb_disp_cursor;

    logic       clk = 1'b0;
    logic       rst, rot_a, rot_b, rot_push;
    logic [1:0] chan_sel;
    logic [4:0] addr_w;
    logic [3:0] addr_s;
    logic       up_w, dn_w, chg_w, err_w;
    logic       up_s, dn_s, chg_s, err_s;

    always #5 clk = ~clk;

    disp_cursor #(.CHANNELS(4), .CH_W(2), .ADDR_W(5), .ADDR_MAX(31), .SATURATE(0)) u_w (
        .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .rot_push(rot_push),
        .chan_sel(chan_sel), .addr(addr_w), .step_up(up_w), .step_dn(dn_w),
        .changed(chg_w), .seq_err(err_w)
    );

    disp_cursor #(.CHANNELS(3), .CH_W(2), .ADDR_W(4), .ADDR_MAX(12), .SATURATE(1)) u_s (
        .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .rot_push(rot_push),
        .chan_sel(chan_sel), .addr(addr_s), .step_up(up_s), .step_dn(dn_s),
        .changed(chg_s), .seq_err(err_s)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // reference model: encoder displacement since rest, gray position 00,10,11,01 = 0..3
    int         cw [4];
    int         cs [3];
    int         m_d, m_last;
    bit         m_wait, m_fresh, s_valid, s_push, s_push_prev;
    logic [1:0] s_ab;
    bit         e_up, e_dn, e_err, e_chg_w, e_chg_s;
    int         e_addr_w, e_addr_s;
    int         cnt_up_w, cnt_dn_w, cnt_err_w, cnt_chg_w, cnt_up_s, cnt_dn_s, cnt_chg_s;

    function automatic int pos_of(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic quad_eval(input logic [1:0] c);
        int delta;
        if (m_wait) begin
            if (c == 2'b00) begin
                m_wait = 1'b0;
                m_d    = 0;
            end
            m_last = pos_of(c);
        end else begin
            delta = (pos_of(c) - m_last + 4) % 4;
            if (delta == 1) m_d++;
            else if (delta == 3) m_d--;
            else if (delta == 2) begin
                e_err  = 1'b1;
                m_wait = 1'b1;
                m_d    = 0;
            end
            m_last = pos_of(c);
            if (!m_wait && c == 2'b00) begin
                if (m_d == 4) e_dn = 1'b1;
                else if (m_d == -4) e_up = 1'b1;
                m_d = 0;
            end
        end
    endtask

    task automatic clr_counts();
        cnt_up_w = 0; cnt_dn_w = 0; cnt_err_w = 0; cnt_chg_w = 0;
        cnt_up_s = 0; cnt_dn_s = 0; cnt_chg_s = 0;
    endtask

    task automatic tick(input bit r, input bit a, input bit b, input bit p, input logic [1:0] sel);
        bit push_rise;
        rst = r; rot_a = a; rot_b = b; rot_push = p; chan_sel = sel;
        @(posedge clk);
        #1;
        e_up = 1'b0; e_dn = 1'b0; e_err = 1'b0; e_chg_w = 1'b0; e_chg_s = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) cw[i] = 0;
            for (int i = 0; i < 3; i++) cs[i] = 0;
            s_valid = 1'b0; s_ab = 2'b00; s_push = 1'b0; s_push_prev = 1'b0;
            m_wait = 1'b0; m_fresh = 1'b0; m_d = 0; m_last = 0;
        end else begin
            if (s_valid) begin
                if (m_fresh) begin
                    m_fresh = 1'b0;
                    m_last  = pos_of(s_ab);
                    m_wait  = (s_ab != 2'b00);
                    m_d     = 0;
                end else begin
                    quad_eval(s_ab);
                end
            end
            push_rise = s_push && !s_push_prev;
            if (push_rise || e_up || e_dn) begin
                e_chg_w = 1'b1;
                if (push_rise) cw[sel] = 0;
                else if (e_up) cw[sel] = (cw[sel] == 31) ? 0 : cw[sel] + 1;
                else           cw[sel] = (cw[sel] == 0) ? 31 : cw[sel] - 1;
                if (sel < 3) begin
                    e_chg_s = 1'b1;
                    if (push_rise) cs[sel] = 0;
                    else if (e_up) cs[sel] = (cs[sel] >= 12) ? 12 : cs[sel] + 1;
                    else           cs[sel] = (cs[sel] == 0) ? 0 : cs[sel] - 1;
                end
            end
            s_push_prev = s_push;
            s_push      = p;
            s_ab        = {a, b};
            if (!s_valid) begin
                s_valid = 1'b1;
                m_fresh = 1'b1;
            end
        end
        e_addr_w = cw[sel];
        e_addr_s = (sel < 3) ? cs[sel] : 0;
        cnt_up_w += int'(up_w); cnt_dn_w += int'(dn_w); cnt_err_w += int'(err_w);
        cnt_chg_w += int'(chg_w); cnt_up_s += int'(up_s); cnt_dn_s += int'(dn_s);
        cnt_chg_s += int'(chg_s);
    endtask

    task automatic detent_b(input logic [1:0] sel, input bit p_last);
        tick(0, 0, 1, 0, sel); tick(0, 1, 1, 0, sel); tick(0, 1, 0, 0, sel); tick(0, 0, 0, p_last, sel);
    endtask

    task automatic detent_a(input logic [1:0] sel);
        tick(0, 1, 0, 0, sel); tick(0, 1, 1, 0, sel); tick(0, 0, 1, 0, sel); tick(0, 0, 0, 0, sel);
    endtask

    task automatic idle(input int n, input logic [1:0] sel);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, sel);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1, 1'($urandom), 1'($urandom), 1'($urandom), 2'd0);
        n_asrt++;
        if ({up_w, dn_w, chg_w, err_w} !== 4'b0) begin
            n_fail++; $display("FAIL reset_pulses_w got=%b exp=0000", {up_w, dn_w, chg_w, err_w});
        end
        n_asrt++;
        if ({up_s, dn_s, chg_s, err_s} !== 4'b0) begin
            n_fail++; $display("FAIL reset_pulses_s got=%b exp=0000", {up_s, dn_s, chg_s, err_s});
        end
        idle(2, 2'd0);
        n_asrt++;
        if (addr_w !== 5'd0 || addr_s !== 4'd0) begin
            n_fail++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", addr_w, addr_s);
        end
    endtask

    task automatic test_wrap_up();
        detent_a(2'd0); idle(1, 2'd0);
        n_asrt++;
        if (addr_w !== 5'd31) begin
            n_fail++; $display("FAIL wrap_down got=%0d exp=31", addr_w);
        end
        clr_counts();
        detent_b(2'd0, 1'b0);
        n_asrt++;
        if (up_w !== 1'b0) begin
            n_fail++; $display("FAIL step_early got=%b exp=0", up_w);
        end
        tick(0, 0, 0, 0, 2'd0);
        n_asrt++;
        if ({up_w, chg_w, addr_w} !== {1'b1, 1'b1, 5'd0}) begin
            n_fail++; $display("FAIL wrap_up got up=%b chg=%b addr=%0d exp up=1 chg=1 addr=0", up_w, chg_w, addr_w);
        end
        idle(2, 2'd0);
        n_asrt++;
        if (cnt_up_w !== 1 || cnt_chg_w !== 1) begin
            n_fail++; $display("FAIL wrap_once got up=%0d chg=%0d exp 1/1", cnt_up_w, cnt_chg_w);
        end
    endtask

    task automatic test_saturate();
        clr_counts();
        detent_a(2'd2); detent_a(2'd2); idle(2, 2'd2);
        n_asrt++;
        if (cnt_dn_s !== 2 || cnt_chg_s !== 2 || addr_s !== 4'd0) begin
            n_fail++; $display("FAIL sat_low got dn=%0d chg=%0d addr=%0d exp 2/2/0", cnt_dn_s, cnt_chg_s, addr_s);
        end
        n_asrt++;
        if (addr_w !== 5'd30) begin
            n_fail++; $display("FAIL wrap_two_dn got=%0d exp=30", addr_w);
        end
    endtask

    task automatic test_partial();
        clr_counts();
        tick(0, 1, 0, 0, 2'd3); tick(0, 1, 1, 0, 2'd3); tick(0, 1, 0, 0, 2'd3);
        idle(3, 2'd3);
        n_asrt++;
        if (cnt_up_w + cnt_dn_w + cnt_err_w + cnt_chg_w !== 0 || addr_w !== 5'd0) begin
            n_fail++; $display("FAIL partial got up=%0d dn=%0d err=%0d chg=%0d addr=%0d exp all 0",
                               cnt_up_w, cnt_dn_w, cnt_err_w, cnt_chg_w, addr_w);
        end
    endtask

    task automatic test_illegal();
        clr_counts();
        tick(0, 1, 1, 0, 2'd3); tick(0, 0, 1, 0, 2'd3); idle(3, 2'd3);
        n_asrt++;
        if (cnt_err_w !== 1 || cnt_up_w + cnt_dn_w !== 0) begin
            n_fail++; $display("FAIL illegal got err=%0d steps=%0d exp 1/0", cnt_err_w, cnt_up_w + cnt_dn_w);
        end
        clr_counts();
        detent_b(2'd3, 1'b0); idle(1, 2'd3);
        n_asrt++;
        if (cnt_up_w !== 1 || addr_w !== 5'd1) begin
            n_fail++; $display("FAIL after_illegal got up=%0d addr=%0d exp 1/1", cnt_up_w, addr_w);
        end
    endtask

    task automatic test_push_step();
        tick(0, 0, 0, 1, 2'd1); idle(2, 2'd1);
        for (int i = 0; i < 7; i++) detent_b(2'd1, 1'b0);
        idle(1, 2'd1);
        n_asrt++;
        if (addr_w !== 5'd7 || addr_s !== 4'd7) begin
            n_fail++; $display("FAIL ch1_seven got=%0d/%0d exp=7/7", addr_w, addr_s);
        end
        detent_b(2'd1, 1'b1);
        tick(0, 0, 0, 1, 2'd1);
        n_asrt++;
        if ({up_w, chg_w, addr_w, up_s, addr_s} !== {1'b1, 1'b1, 5'd0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL push_wins got up=%b chg=%b addr=%0d up_s=%b addr_s=%0d exp 1 1 0 1 0",
                               up_w, chg_w, addr_w, up_s, addr_s);
        end
        tick(0, 0, 0, 0, 2'd0);
        n_asrt++;
        if (addr_w !== 5'd0 || addr_s !== 4'd1 || chg_w !== 1'b0) begin
            n_fail++; $display("FAIL ch0_kept got=%0d/%0d chg=%b exp=0/1 chg=0", addr_w, addr_s, chg_w);
        end
        tick(0, 0, 0, 0, 2'd2);
        n_asrt++;
        if (addr_w !== 5'd30 || addr_s !== 4'd0) begin
            n_fail++; $display("FAIL ch2_kept got=%0d/%0d exp=30/0", addr_w, addr_s);
        end
        tick(0, 0, 0, 0, 2'd3);
        n_asrt++;
        if (addr_w !== 5'd1) begin
            n_fail++; $display("FAIL ch3_kept got=%0d exp=1", addr_w);
        end
    endtask

    task automatic test_out_of_range();
        clr_counts();
        detent_b(2'd3, 1'b0); idle(2, 2'd3);
        n_asrt++;
        if (cnt_up_s !== 1 || cnt_chg_s !== 0 || addr_s !== 4'd0) begin
            n_fail++; $display("FAIL oor got up=%0d chg=%0d addr=%0d exp 1/0/0", cnt_up_s, cnt_chg_s, addr_s);
        end
        n_asrt++;
        if (cnt_chg_w !== 1 || addr_w !== 5'd2) begin
            n_fail++; $display("FAIL oor_w got chg=%0d addr=%0d exp 1/2", cnt_chg_w, addr_w);
        end
    endtask

    task automatic test_back_to_back();
        clr_counts();
        for (int i = 0; i < 14; i++) detent_b(2'd1, 1'b0);
        idle(2, 2'd1);
        n_asrt++;
        if (cnt_up_w !== 14 || addr_w !== 5'd14) begin
            n_fail++; $display("FAIL b2b_w got up=%0d addr=%0d exp 14/14", cnt_up_w, addr_w);
        end
        n_asrt++;
        if (cnt_chg_s !== 14 || addr_s !== 4'd12) begin
            n_fail++; $display("FAIL b2b_sat got chg=%0d addr=%0d exp 14/12", cnt_chg_s, addr_s);
        end
    endtask

    task automatic test_reset_mid();
        clr_counts();
        tick(1, 1, 0, 0, 2'd0); tick(1, 1, 0, 0, 2'd0);
        tick(0, 1, 0, 0, 2'd0); tick(0, 1, 0, 0, 2'd0);
        tick(0, 1, 1, 0, 2'd0); tick(0, 0, 1, 0, 2'd0); idle(3, 2'd0);
        n_asrt++;
        if (cnt_up_w + cnt_dn_w + cnt_up_s + cnt_dn_s !== 0) begin
            n_fail++; $display("FAIL reset_mid_step got=%0d exp=0", cnt_up_w + cnt_dn_w + cnt_up_s + cnt_dn_s);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 2'(i));
            n_asrt++;
            if (addr_w !== 5'd0) begin
                n_fail++; $display("FAIL reset_mid_ch%0d got=%0d exp=0", i, addr_w);
            end
        end
        clr_counts();
        detent_a(2'd0); idle(1, 2'd0);
        n_asrt++;
        if (cnt_dn_w !== 1 || addr_w !== 5'd31) begin
            n_fail++; $display("FAIL reset_mid_next got dn=%0d addr=%0d exp 1/31", cnt_dn_w, addr_w);
        end
    endtask

    task automatic test_random();
        int         p   = 0;
        int         dir = 1;
        int         r;
        bit         push = 1'b0;
        logic [1:0] sel  = 2'd0;
        logic [1:0] code;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) p += dir;
            else if (r < 70) p -= dir;
            else if (r < 92) p = p;
            else if (r < 97) p += 2;
            else dir = -dir;
            if ($urandom_range(0, 9) == 0) push = ~push;
            if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
            code = code_of(p);
            tick(($urandom_range(0, 299) == 0), code[1], code[0], push, sel);
            n_asrt++;
            if ({up_w, dn_w, chg_w, err_w, addr_w} !== {e_up, e_dn, e_chg_w, e_err, 5'(e_addr_w)}) begin
                n_fail++; $display("FAIL rand_w cyc=%0d got=%b exp=%b", cyc,
                                   {up_w, dn_w, chg_w, err_w, addr_w}, {e_up, e_dn, e_chg_w, e_err, 5'(e_addr_w)});
            end
            n_asrt++;
            if ({up_s, dn_s, chg_s, err_s, addr_s} !== {e_up, e_dn, e_chg_s, e_err, 4'(e_addr_s)}) begin
                n_fail++; $display("FAIL rand_s cyc=%0d got=%b exp=%b", cyc,
                                   {up_s, dn_s, chg_s, err_s, addr_s}, {e_up, e_dn, e_chg_s, e_err, 4'(e_addr_s)});
            end
        end
    endtask

    initial begin
        clr_counts();
        test_reset();
        test_wrap_up();
        test_saturate();
        test_partial();
        test_illegal();
        test_push_step();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
